line_sq_diff_sum: RTL and testbench
===================================

# line_sq_diff_sum

Upstream feeder of `Line_sum_Accumulator`. Consumes a stream of pixel pairs (reference, test) and computes the per-line sum of squared differences. Presents one `line_sum` per completed line, with a single-cycle `line_valid` strobe. The output width matches the accumulator's `line_sum` input exactly, so the two blocks connect directly.

## Interface
- `LINE_SIZE`, default 640: pixels per line; must be at least 2.
- `PIXEL_SIZE`, default 8: bits per unsigned pixel.
- `CLK`  in  1  clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `pix_valid`  in  1  pixel pair present this cycle; gaps allowed anywhere.
- `pix_a`  in  PIXEL_SIZE  reference pixel, unsigned.
- `pix_b`  in  PIXEL_SIZE  test pixel, unsigned.
- `line_restart`  in  1  discard the partial line; the next accepted pixel is pixel 0.
- `line_sum`  out  $clog2(LINE_SIZE)+2*PIXEL_SIZE  sum of (pix_a-pix_b)^2 over the last completed line.
- `line_valid`  out  1  one-cycle strobe: `line_sum` just updated.
- `busy`  out  1  a line is partially received or the pipeline holds data.

## Operation
- The pixel counter `pix_cnt` is `max(1,$clog2(LINE_SIZE))` bits wide.
  - Increments on each accepted pixel (`pix_valid`=1).
  - When it reaches LINE_SIZE-1, that pixel is tagged `last` and the counter wraps to 0.
- Stage 1 (sampling edge):
  - `d1 <= |pix_a - pix_b|`, PIXEL_SIZE bits, unsigned.
  - `v1 <= pix_valid`, `l1 <= last`.
- Stage 2: `sq2 <= d1*d1`, 2*PIXEL_SIZE bits, unsigned; `v2`/`l2` follow `v1`/`l1`.
- Stage 3 (accumulate, effective only when `v2`=1):
  - `acc <= acc + sq2`.
  - If `l2`=1: `line_sum <= acc + sq2`, `line_valid <= 1`, `acc <= 0`.
- Width rule: `acc` and `line_sum` are $clog2(LINE_SIZE)+2*PIXEL_SIZE bits. (2^P-1)^2·LINE_SIZE fits in this width, so there is no overflow and no saturation.
- The line phase is an implicit two-state FSM:
  - IDLE: `pix_cnt`=0 and the pipeline is empty.
  - ACCUM: otherwise.
  - `busy` = (`pix_cnt`≠0) | `v1` | `v2`.
- `line_restart`:
  - Clears `pix_cnt` and `acc`, and clears `v1`/`v2` of any pixels belonging to the aborted line.
  - A `line_sum` already registered is kept.
  - `line_restart` and `pix_valid` in the same cycle: the pixel is accepted as pixel 0 of the new line.
  - A restart arriving while a completed line is still in stage 1 or stage 2 (tagged `last`) does not kill that line. Only untagged partial-line pixels are flushed.
- Back-to-back lines: pixel 0 of line N+1 may immediately follow the last pixel of line N. No bubble and no cross-line mixing.
- `line_sum` holds its value until the next completed line.

## Timing
- Reset (synchronous, edge with `reset`=1) produces:
  - `line_sum`=0, `line_valid`=0, `busy`=0.
  - `pix_cnt`=0, `acc`=0, `v1`=`v2`=0.
- `reset` has priority over `line_restart` and `pix_valid`.
- Reset mid-line: the partial line is discarded with no `line_valid`. The first pixel after reset deasserts is pixel 0.
- Latency: for the last pixel sampled at edge E0, `line_sum`/`line_valid` update at edge E0+2. They are visible in the cycle after E0+2, i.e. 3 cycles from pixel presentation.
- `line_valid` is high for exactly one cycle per completed line.
- Maximum rate is one line per LINE_SIZE cycles, with `line_valid` strobes exactly LINE_SIZE cycles apart.
- Gaps in `pix_valid` delay `line_valid` by the same number of cycles and have no effect on the result.

## Test plan
All scenarios run with LINE_SIZE=4, PIXEL_SIZE=8 (`line_sum` is 18 bits).
- Basic line: a={10,20,30,40}, b={13,16,30,50}, consecutive cycles.
  - `line_sum`=125 (9+16+0+100).
  - `line_valid` one cycle, 3 cycles after the 4th pixel is presented.
- Max value: a=255, b=0 for 4 pixels.
  - `line_sum`=260100, no wrap.
  - Repeat with a=0, b=255: 260100 (absolute difference checked).
- Back-to-back: basic line immediately followed by a line with a=b={7,7,7,7}.
  - `line_valid` strobes 4 cycles apart, with values 125 then 0.
- Gapped input: basic line with `pix_valid` low for 3 cycles between pixels 1 and 2.
  - `line_sum`=125, `line_valid` delayed by 3 cycles.
- Restart: 2 pixels (diff 50 each), then `line_restart` coincident with a pixel of diff 1, then 3 pixels of diff 2.
  - `line_sum`=13 (1+4+4+4).
  - No strobe for the aborted line; `busy` 0 after the strobe.
- Reset mid-line: 3 pixels of diff 100, then `reset` for 1 cycle, then the basic line.
  - All outputs 0 after reset.
  - Exactly one `line_valid`, with `line_sum`=125.

Source files
------------

// File: rtl/line_sq_diff_sum.sv
`default_nettype none
// ============================================================================
//  Module   : line_sq_diff_sum
//  Purpose  : Streams (reference, test) pixel pairs through a three-stage
//             |a-b| -> square -> accumulate pipeline and presents one
//             sum-of-squared-differences per completed line with a
//             single-cycle line_valid strobe.
//  Revision : 1.0 - initial release
// ============================================================================
module line_sq_diff_sum #(
  parameter int LINE_SIZE  = 640,
  parameter int PIXEL_SIZE = 8
) (
  input  logic                                          CLK,
  input  logic                                          reset,
  input  logic                                          pix_valid,
  input  logic [PIXEL_SIZE-1:0]                         pix_a,
  input  logic [PIXEL_SIZE-1:0]                         pix_b,
  input  logic                                          line_restart,
  output logic [$clog2(LINE_SIZE)+2*PIXEL_SIZE-1:0]     line_sum,
  output logic                                          line_valid,
  output logic                                          busy
);

  localparam int CW  = ($clog2(LINE_SIZE) > 1) ? $clog2(LINE_SIZE) : 1;
  localparam int SQW = 2 * PIXEL_SIZE;
  localparam int SW  = $clog2(LINE_SIZE) + SQW;
  localparam logic [CW-1:0] LAST_IDX = CW'(LINE_SIZE - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } phase_t;

  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  w_last;
  logic [PIXEL_SIZE-1:0] w_diff;

  logic [PIXEL_SIZE-1:0] d1_q;
  logic                  v1_q, l1_q;
  logic [SQW-1:0]        sq2_q;
  logic                  v2_q, l2_q;
  logic [SW-1:0]         acc_q;
  logic [SW-1:0]         line_sum_q;
  logic                  line_valid_q;

  logic [SQW-1:0]        w_d1_ext;
  logic [SW-1:0]         w_acc_sum;
  logic                  w_flush;
  phase_t                w_phase;

  // Pixel counter next state; a restart makes the coincident pixel pixel 0.
  always_comb begin
    cnt_d  = cnt_q;
    w_last = 1'b0;
    if (line_restart) begin
      cnt_d = '0;
    end
    if (pix_valid) begin
      if (line_restart) begin
        cnt_d = CW'(1);
      end else if (cnt_q == LAST_IDX) begin
        cnt_d  = '0;
        w_last = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Pixel counter register.
  always_ff @(posedge CLK) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign w_diff = (pix_a >= pix_b) ? (pix_a - pix_b) : (pix_b - pix_a);

  // Stage 1: absolute difference plus valid/last tags.
  always_ff @(posedge CLK) begin
    if (reset) begin
      d1_q <= '0;
      v1_q <= 1'b0;
      l1_q <= 1'b0;
    end else begin
      d1_q <= w_diff;
      v1_q <= pix_valid;
      l1_q <= w_last;
    end
  end

  assign w_d1_ext = {{PIXEL_SIZE{1'b0}}, d1_q};

  // Stage 2: square; an untagged stage-1 pixel dies on restart.
  always_ff @(posedge CLK) begin
    if (reset) begin
      sq2_q <= '0;
      v2_q  <= 1'b0;
      l2_q  <= 1'b0;
    end else begin
      sq2_q <= w_d1_ext * w_d1_ext;
      v2_q  <= v1_q & (l1_q | ~line_restart);
      l2_q  <= l1_q;
    end
  end

  assign w_acc_sum = acc_q + {{(SW-SQW){1'b0}}, sq2_q};

  // A restart flushes the partial line unless its last pixel is already in
  // stage 1, in which case the stage-2 pixel still belongs to a live line.
  assign w_flush = line_restart & ~(v1_q & l1_q);

  // Stage 3: accumulate and publish the line total on the tagged pixel.
  always_ff @(posedge CLK) begin
    if (reset) begin
      acc_q        <= '0;
      line_sum_q   <= '0;
      line_valid_q <= 1'b0;
    end else begin
      line_valid_q <= 1'b0;
      if (v2_q && l2_q) begin
        line_sum_q   <= w_acc_sum;
        line_valid_q <= 1'b1;
        acc_q        <= '0;
      end else if (w_flush) begin
        acc_q <= '0;
      end else if (v2_q) begin
        acc_q <= w_acc_sum;
      end
    end
  end

  // Implicit line phase: idle only when no partial line and empty pipeline.
  always_comb begin
    w_phase = IDLE;
    if ((cnt_q != '0) || v1_q || v2_q) begin
      w_phase = ACCUM;
    end
  end

  assign busy       = (w_phase == ACCUM);
  assign line_sum   = line_sum_q;
  assign line_valid = line_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_line_sq_diff_sum.sv
`default_nettype none
// ============================================================================
//  Module   : tb_line_sq_diff_sum
//  Purpose  : Self-checking bench for line_sq_diff_sum (LINE_SIZE=4,
//             PIXEL_SIZE=8): directed scenarios plus random traffic against
//             a line-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_line_sq_diff_sum;

  localparam int LS = 4;
  localparam int PS = 8;

  logic        CLK;
  logic        reset;
  logic        pix_valid;
  logic [7:0]  pix_a;
  logic [7:0]  pix_b;
  logic        line_restart;
  logic [17:0] line_sum;
  logic        line_valid;
  logic        busy;

  int errors;
  int checks;

  // Reference model state
  int edge_n;
  int m_cnt;
  int m_sum;
  int due_q[$];
  int val_q[$];
  int exp_sum;
  bit exp_valid;
  int last_tag_edge;
  int last_untag_edge;
  int strobes;

  line_sq_diff_sum #(
    .LINE_SIZE (LS),
    .PIXEL_SIZE(PS)
  ) dut (
    .CLK         (CLK),
    .reset       (reset),
    .pix_valid   (pix_valid),
    .pix_a       (pix_a),
    .pix_b       (pix_b),
    .line_restart(line_restart),
    .line_sum    (line_sum),
    .line_valid  (line_valid),
    .busy        (busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Line-level model: a line's total is the sum of squared differences of
  // its LS accepted pixels, published two edges after the last one is taken.
  task automatic model_edge(input bit v, input int a, input int b, input bit rs, input bit rr);
    int d;
    edge_n++;
    if (rr) begin
      m_cnt = 0; m_sum = 0; exp_sum = 0; exp_valid = 0;
      due_q.delete(); val_q.delete();
      last_tag_edge = -10; last_untag_edge = -10;
      return;
    end
    exp_valid = 0;
    if (due_q.size() > 0 && due_q[0] == edge_n) begin
      exp_sum   = val_q[0];
      exp_valid = 1;
      void'(due_q.pop_front());
      void'(val_q.pop_front());
    end
    if (rs) begin
      m_cnt = 0; m_sum = 0; last_untag_edge = -10;
    end
    if (v) begin
      d = (a > b) ? a - b : b - a;
      m_sum += d * d;
      m_cnt++;
      if (m_cnt == LS) begin
        due_q.push_back(edge_n + 2);
        val_q.push_back(m_sum);
        m_cnt = 0; m_sum = 0;
        last_tag_edge = edge_n;
      end else begin
        last_untag_edge = edge_n;
      end
    end
  endtask

  task automatic step(input bit v, input int a, input int b, input bit rs, input bit rr);
    bit exp_busy;
    pix_valid    = v;
    pix_a        = a[7:0];
    pix_b        = b[7:0];
    line_restart = rs;
    reset        = rr;
    @(posedge CLK);
    model_edge(v, a, b, rs, rr);
    @(negedge CLK);
    exp_busy = (m_cnt != 0) || (edge_n - last_tag_edge < 2) || (edge_n - last_untag_edge < 2);
    check("line_valid", {31'd0, line_valid}, {31'd0, exp_valid});
    check("line_sum", {14'd0, line_sum}, exp_sum);
    check("busy", {31'd0, busy}, {31'd0, exp_busy});
    if (line_valid === 1'b1) strobes++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  task automatic basic_line();
    step(1, 10, 13, 0, 0);
    step(1, 20, 16, 0, 0);
    step(1, 30, 30, 0, 0);
    step(1, 40, 50, 0, 0);
  endtask

  initial begin
    errors = 0; checks = 0; edge_n = 0; strobes = 0;
    m_cnt = 0; m_sum = 0; exp_sum = 0; exp_valid = 0;
    last_tag_edge = -10; last_untag_edge = -10;
    pix_valid = 0; pix_a = 0; pix_b = 0; line_restart = 0; reset = 1;

    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    check("reset_sum", {14'd0, line_sum}, 0);
    check("reset_busy", {31'd0, busy}, 0);

    // Basic line: strobe 3 cycles after the 4th pixel is presented
    basic_line();
    step(0, 0, 0, 0, 0);
    check("basic_no_early", {31'd0, line_valid}, 0);
    step(0, 0, 0, 0, 0);
    check("basic_strobe", {31'd0, line_valid}, 1);
    check("basic_sum", {14'd0, line_sum}, 125);
    idle(3);
    check("basic_hold", {14'd0, line_sum}, 125);

    // Max value, both polarities
    for (int i = 0; i < LS; i++) step(1, 255, 0, 0, 0);
    idle(3);
    check("max_sum", {14'd0, line_sum}, 260100);
    for (int i = 0; i < LS; i++) step(1, 0, 255, 0, 0);
    idle(3);
    check("max_sum_rev", {14'd0, line_sum}, 260100);

    // Back-to-back lines
    strobes = 0;
    basic_line();
    for (int i = 0; i < LS; i++) step(1, 7, 7, 0, 0);
    idle(4);
    check("b2b_strobes", strobes, 2);
    check("b2b_sum", {14'd0, line_sum}, 0);

    // Gapped input
    step(1, 10, 13, 0, 0);
    step(1, 20, 16, 0, 0);
    idle(3);
    step(1, 30, 30, 0, 0);
    step(1, 40, 50, 0, 0);
    idle(3);
    check("gap_sum", {14'd0, line_sum}, 125);

    // Restart with coincident pixel
    strobes = 0;
    step(1, 100, 50, 0, 0);
    step(1, 0, 50, 0, 0);
    step(1, 5, 4, 1, 0);
    for (int i = 0; i < 3; i++) step(1, 2, 0, 0, 0);
    idle(3);
    check("restart_sum", {14'd0, line_sum}, 13);
    check("restart_strobes", strobes, 1);
    check("restart_busy", {31'd0, busy}, 0);

    // Reset mid-line
    for (int i = 0; i < 3; i++) step(1, 100, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    check("rst_sum", {14'd0, line_sum}, 0);
    check("rst_valid", {31'd0, line_valid}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    strobes = 0;
    basic_line();
    idle(4);
    check("rst_strobes", strobes, 1);
    check("rst_line_sum", {14'd0, line_sum}, 125);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      bit v, rs, rr;
      int a, b;
      v  = ($urandom_range(0, 9) < 7);
      rs = ($urandom_range(0, 29) == 0);
      rr = ($urandom_range(0, 199) == 0);
      a  = ($urandom_range(0, 5) == 0) ? 255 : $urandom_range(0, 255);
      b  = ($urandom_range(0, 5) == 0) ? 0   : $urandom_range(0, 255);
      step(v, a, b, rs, rr);
    end
    idle(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
